fetch_stage_ctrl: RTL and testbench
===================================

# fetch_stage_ctrl

Instruction-fetch control stage for the MIPS pipeline. Holds the PC, issues requests to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register. It consumes the branch-taken result and target produced by the ID-stage branch condition checker, redirecting the PC and flushing IF/ID on a taken branch. It honours the hazard unit's stall.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- stall  input  1  hazard-unit stall; freezes IF/ID and PC advance.
- branch_taken  input  1  taken-branch/jump result from the ID-stage condition checker.
- branch_target  input  32  redirect address, valid when branch_taken=1.
- imem_req  output  1  instruction-memory request; held until ack.
- imem_addr  output  32  fetch address; stable while imem_req=1.
- imem_ack  input  1  memory completion; may arrive in the same cycle as req.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- ifid_instr  output  32  IF/ID instruction.
- ifid_pc4  output  32  IF/ID PC+4 of that instruction.
- ifid_valid  output  1  IF/ID holds a live instruction.

## Operation
- Registers: pc_q (next fetch address), fa_q (address of outstanding request, drives imem_addr), hold buffer (instr + pc4), FSM state, IF/ID triple.
- FSM states: IDLE, FETCH, HOLD, DRAIN.
- IDLE: entered on reset; req=0; next cycle -> FETCH with fa_q=pc_q.
- FETCH: req=1, addr=fa_q.
  - ack & !stall: IF/ID <= {rdata, fa_q+4, valid=1}; pc_q, fa_q <= fa_q+4; stay FETCH.
  - ack & stall: hold buffer <= {rdata, fa_q+4}; pc_q <= fa_q+4; -> HOLD.
  - no ack: stay FETCH, fa_q unchanged.
- HOLD: req=0. When !stall: IF/ID <= hold buffer, valid=1; fa_q <= pc_q; -> FETCH.
- DRAIN: req=1 with old fa_q (handshake must complete). On ack: data discarded; fa_q <= pc_q; -> FETCH.
- Redirect (branch_taken=1), highest priority, overrides stall:
  - pc_q <= {branch_target[31:2], 2'b00}; ifid_valid <= 0; hold buffer discarded.
  - In FETCH without ack: -> DRAIN.
  - In FETCH with ack: data discarded; fa_q <= target; stay FETCH.
  - In HOLD or DRAIN: -> FETCH (HOLD) or remain DRAIN with the updated pc_q. A later redirect in DRAIN overwrites pc_q.
  - In IDLE: pc_q <= target.
- Stall without redirect: ifid_* hold value; pc_q does not advance past a captured word.
- Arithmetic: +4 is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, ifid_instr=0 (NOP), ifid_pc4=0, ifid_valid=0, state=IDLE, pc_q=fa_q=RESET_PC.
- First req is asserted in the 2nd cycle after rst_n rises.
- Latency: ack at edge N -> ifid_valid=1 with that word after edge N.
- Throughput: with ack tied high, one instruction per cycle.
- Taken branch: bubble; ifid_valid=0 in the cycle after branch_taken. The first target fetch is requested in the same next cycle (FETCH path) or after the drain ack (DRAIN path).
- Async reset mid-request: imem_req drops immediately. The outstanding transaction is abandoned, and memory must tolerate this.
- imem_addr never changes while imem_req=1 and ack=0.

## Test plan
- Reset then ack tied high, memory[i]=i: ifid_pc4 sequence 4,8,12,… on consecutive cycles; ifid_instr=0,1,2…; first valid in the 3rd cycle after rst_n rises.
- ack with 3-cycle latency: imem_addr is stable for 3 cycles per fetch; ifid_valid pulses once per 3 cycles; no duplicated or dropped PCs.
- stall high for 4 cycles while ack arrives: HOLD entered, req=0, IF/ID unchanged. After stall drops, the buffered word appears, then fetch resumes at the next PC.
- branch_taken with target 32'h0000_0100 during an outstanding 3-cycle fetch: old addr is held until ack, the returned data does not reach IF/ID, ifid_valid=0, and the next request addr=0x100.
- branch_taken and stall together with target 0x200: ifid_valid=0 next cycle; fetch resumes at 0x200. Target 0x203 fetches 0x200.
- PC at 32'hFFFF_FFFC, ack high: ifid_pc4=0 and next imem_addr=0. Assert rst_n low mid-FETCH: outputs immediately take reset values.

Source files
------------

// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch control: owns the PC, runs the imem req/ack handshake and
// loads IF/ID, with taken-branch redirect/flush and hazard stall.
//
//   state | meaning
//   IDLE  | post-reset, no request; next cycle starts fetching at pc_q
//   FETCH | request outstanding at fa_q; word goes to IF/ID or hold buffer
//   HOLD  | word captured under stall; no request until stall drops
//   DRAIN | redirected mid-request; finish old handshake, discard its data
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fa_q, fa_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] ifid_instr_d, ifid_pc4_d;
  logic        ifid_valid_d;
  logic [31:0] tgt;
  logic [31:0] fa_pc4;

  // Targets are word-aligned; low two bits of the redirect are ignored.
  assign tgt       = {branch_target[31:2], 2'b00};
  assign fa_pc4    = fa_q + 32'd4;
  assign imem_addr = fa_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fa_d         = fa_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    ifid_instr_d = ifid_instr;
    ifid_pc4_d   = ifid_pc4;
    ifid_valid_d = ifid_valid;
    imem_req     = 1'b0;

    // An unstalled cycle without a fresh word leaves a bubble in IF/ID.
    if (!stall) ifid_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        fa_d    = pc_q;
        if (branch_taken) begin
          pc_d = tgt;
          fa_d = tgt;
        end
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pc_d = tgt;
          if (imem_ack) fa_d = tgt;
          else          state_d = S_DRAIN;
        end else if (imem_ack) begin
          pc_d = fa_pc4;
          if (!stall) begin
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = fa_pc4;
            ifid_valid_d = 1'b1;
            fa_d         = fa_pc4;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = fa_pc4;
            state_d      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          pc_d    = tgt;
          fa_d    = tgt;
          state_d = S_FETCH;
        end else if (!stall) begin
          ifid_instr_d = hold_instr_q;
          ifid_pc4_d   = hold_pc4_q;
          ifid_valid_d = 1'b1;
          fa_d         = pc_q;
          state_d      = S_FETCH;
        end
      end

      S_DRAIN: begin
        imem_req = 1'b1;
        if (branch_taken) pc_d = tgt;
        if (imem_ack) begin
          fa_d    = branch_taken ? tgt : pc_q;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (branch_taken) ifid_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      fa_q         <= RESET_PC;
      hold_instr_q <= 32'd0;
      hold_pc4_q   <= 32'd0;
      ifid_instr   <= 32'd0;
      ifid_pc4     <= 32'd0;
      ifid_valid   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fa_q         <= fa_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      ifid_instr   <= ifid_instr_d;
      ifid_pc4     <= ifid_pc4_d;
      ifid_valid   <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: directed scenarios plus random stall/redirect/latency
// traffic checked against an instruction-stream model of expected PCs.
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  always #5 clk = ~clk;

  fetch_stage_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  bit          chk_en = 1'b0;
  logic [31:0] exp_next = 32'd4;
  int          cur_lat = 0;
  int          waited = 0;
  bit          rand_lat = 1'b0;
  int          deliveries = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  // Memory image: the word at byte address a is its word index.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  // Called at a negedge: drive memory response and control inputs for the
  // coming posedge, then check the outcome at the following negedge.
  task automatic tick(input bit s, input bit b, input logic [31:0] t);
    logic        p_req, p_ack, p_valid;
    logic [31:0] p_addr, p_instr, p_pc4;
    imem_ack      = imem_req && (waited >= cur_lat);
    imem_rdata    = imem_ack ? word_at(imem_addr) : 32'hDEAD_BEEF;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    p_req   = imem_req;
    p_ack   = imem_ack;
    p_addr  = imem_addr;
    p_instr = ifid_instr;
    p_pc4   = ifid_pc4;
    p_valid = ifid_valid;
    @(negedge clk);
    if (p_req && !p_ack) waited++;
    else begin
      waited = 0;
      if (rand_lat) cur_lat = $urandom_range(0, 3);
    end
    if (chk_en) begin
      if (p_req && !p_ack) begin
        chk("req_held", {31'd0, imem_req}, 32'd1);
        chk("addr_stable", imem_addr, p_addr);
      end
      if (b) begin
        chk("bubble", {31'd0, ifid_valid}, 32'd0);
        exp_next = {t[31:2], 2'b00} + 32'd4;
      end else if (s) begin
        chk("stall_instr", ifid_instr, p_instr);
        chk("stall_pc4", ifid_pc4, p_pc4);
        chk("stall_valid", {31'd0, ifid_valid}, {31'd0, p_valid});
      end else if (ifid_valid) begin
        chk("stream_pc4", ifid_pc4, exp_next);
        chk("stream_instr", ifid_instr, word_at(exp_next - 32'd4));
        exp_next = exp_next + 32'd4;
        deliveries++;
      end
    end
  endtask

  task automatic wait_delivery(input int bound);
    int k;
    k = 0;
    do begin
      tick(1'b0, 1'b0, 32'd0);
      k++;
    end while (!ifid_valid && k < bound);
    chk("deliver_timeout", {31'd0, ifid_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] buffered, old_addr;
    int          d0;

    // Reset values.
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_instr", ifid_instr, 32'd0);
    chk("rst_pc4", ifid_pc4, 32'd0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);

    // Ack tied high: one instruction per cycle, first valid in the 3rd cycle.
    rst_n    = 1'b1;
    exp_next = 32'd4;
    chk_en   = 1'b1;
    cur_lat  = 0;
    tick(1'b0, 1'b0, 32'd0);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    chk("first_valid", {31'd0, ifid_valid}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b0, 32'd0);
      chk("tp_valid", {31'd0, ifid_valid}, 32'd1);
      chk("tp_pc4", ifid_pc4, 32'(4 * (k + 1)));
      chk("tp_instr", ifid_instr, 32'(k));
    end

    // Three-cycle memory latency.
    cur_lat = 2;
    d0 = deliveries;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0, 32'd0);
      chk("lat3_valid", {31'd0, ifid_valid}, (i % 3 == 2) ? 32'd1 : 32'd0);
    end
    chk("lat3_count", 32'(deliveries - d0), 32'd4);

    // Stall for 4 cycles while the ack arrives.
    cur_lat  = 0;
    buffered = exp_next;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 32'd0);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
    end
    tick(1'b0, 1'b0, 32'd0);
    chk("hold_out_valid", {31'd0, ifid_valid}, 32'd1);
    chk("hold_out_pc4", ifid_pc4, buffered);
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, buffered);
    tick(1'b0, 1'b0, 32'd0);
    chk("resume_pc4", ifid_pc4, buffered + 32'd4);

    // Redirect during an outstanding 3-cycle fetch.
    cur_lat = 2;
    tick(1'b0, 1'b0, 32'd0);
    old_addr = imem_addr;
    tick(1'b0, 1'b1, 32'h0000_0100);
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, old_addr);
    tick(1'b0, 1'b0, 32'd0);
    chk("drain_valid", {31'd0, ifid_valid}, 32'd0);
    chk("redirect_addr", imem_addr, 32'h0000_0100);
    wait_delivery(12);
    chk("redirect_pc4", ifid_pc4, 32'h0000_0104);

    // Redirect together with stall, then a misaligned target.
    cur_lat = 0;
    tick(1'b1, 1'b1, 32'h0000_0200);
    chk("bs_valid", {31'd0, ifid_valid}, 32'd0);
    wait_delivery(12);
    chk("bs_pc4", ifid_pc4, 32'h0000_0204);
    tick(1'b0, 1'b1, 32'h0000_0203);
    wait_delivery(12);
    chk("align_pc4", ifid_pc4, 32'h0000_0204);
    chk("align_instr", ifid_instr, 32'h0000_0080);

    // PC wrap at the top of the address space.
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_delivery(12);
    chk("wrap_pc4", ifid_pc4, 32'd0);
    chk("wrap_instr", ifid_instr, 32'h3FFF_FFFF);
    chk("wrap_addr", imem_addr, 32'd0);

    // Asynchronous reset in the middle of a request.
    cur_lat = 3;
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst_n    = 1'b0;
    chk_en   = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_addr", imem_addr, 32'd0);
    chk("async_valid", {31'd0, ifid_valid}, 32'd0);
    chk("async_pc4", ifid_pc4, 32'd0);
    chk("async_instr", ifid_instr, 32'd0);
    @(negedge clk);
    waited   = 0;
    exp_next = 32'd4;
    rst_n    = 1'b1;
    chk_en   = 1'b1;

    // Random stall / redirect / latency traffic against the stream model.
    rand_lat = 1'b1;
    cur_lat  = 1;
    d0 = deliveries;
    repeat (600) begin
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom);
    end
    chk("rand_progress", {31'd0, (deliveries - d0) > 50}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
